// File: rtl/computie_bus_recorder.sv
// -----------------------------------------------------------------------------
// computie_bus_recorder
//
// Passive bus monitor. It watches an asynchronous strobe-based bus and
// records one {mod, address, data} entry per bus cycle into a
// first-word-fall-through FIFO, which a consumer drains with a valid/ready
// handshake.
//
// Parameters
//   BITWIDTH : address and data width (multiple of 4)
//   MODWIDTH : cycle modifier width; bit 0 = read(1) / write(0)
//   DEPTH    : record FIFO depth (power of two, >= 4)
//
// Ports
//   comm_clock    in   1                    the only clock
//   comm_reset    in   1                    asynchronous reset, active-high
//   bus_as_n      in   1                    address strobe (async, active-low)
//   bus_dtack_n   in   1                    data acknowledge (async, active-low)
//   bus_mod       in   MODWIDTH             cycle modifier (async)
//   bus_address   in   BITWIDTH             bus address, sampled on an event
//   bus_data      in   BITWIDTH             bus data, sampled on an event
//   record_enable in   1                    capture allowed while high
//   clear         in   1                    synchronous flush
//   out_valid     out  1                    head record present
//   out_ready     in   1                    consumer pops the head
//   out_data      out  2*BITWIDTH+MODWIDTH  head record {mod, address, data}
//   out_empty     out  1                    no record beyond the head
//   level         out  clog2(DEPTH)+1       records held
//   overflow      out  1                    sticky drop flag
//   dropped       out  16                   saturating drop count
// -----------------------------------------------------------------------------
module computie_bus_recorder #(
  parameter int BITWIDTH = 32,
  parameter int MODWIDTH = 1,
  parameter int DEPTH    = 512
) (
  input  logic                             comm_clock,
  input  logic                             comm_reset,
  input  logic                             bus_as_n,
  input  logic                             bus_dtack_n,
  input  logic [MODWIDTH-1:0]              bus_mod,
  input  logic [BITWIDTH-1:0]              bus_address,
  input  logic [BITWIDTH-1:0]              bus_data,
  input  logic                             record_enable,
  input  logic                             clear,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [2*BITWIDTH+MODWIDTH-1:0]   out_data,
  output logic                             out_empty,
  output logic [$clog2(DEPTH):0]           level,
  output logic                             overflow,
  output logic [15:0]                      dropped
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int RW = 2*BITWIDTH + MODWIDTH;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  // ---------------------------------------------------------------------------
  // Two-flop synchronizers, idle value as_n=1, dtack_n=1, mod=0
  // ---------------------------------------------------------------------------
  logic                as_meta, as_sync;
  logic                dtack_meta, dtack_sync;
  logic [MODWIDTH-1:0] mod_meta, mod_sync;

  always_ff @(posedge comm_clock or posedge comm_reset) begin
    if (comm_reset) begin
      as_meta    <= 1'b1;
      as_sync    <= 1'b1;
      dtack_meta <= 1'b1;
      dtack_sync <= 1'b1;
      mod_meta   <= '0;
      mod_sync   <= '0;
    end else begin
      as_meta    <= bus_as_n;
      as_sync    <= as_meta;
      dtack_meta <= bus_dtack_n;
      dtack_sync <= dtack_meta;
      mod_meta   <= bus_mod;
      mod_sync   <= mod_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Event detection
  //
  // The synchronizer holds its forced idle value for two clocks after reset
  // release, so a strobe already low at release would look like a fresh
  // falling edge. settle_cnt counts those two clocks down; the detector only
  // arms once real synchronized samples show the strobes not both low.
  // ---------------------------------------------------------------------------
  logic       both_low;
  logic       prev_both_low;
  logic       armed;
  logic [1:0] settle_cnt;
  logic       bus_event;

  assign both_low  = ~as_sync & ~dtack_sync;
  assign bus_event = armed & both_low & ~prev_both_low;

  always_ff @(posedge comm_clock or posedge comm_reset) begin
    if (comm_reset) begin
      settle_cnt    <= 2'd2;
      armed         <= 1'b0;
      prev_both_low <= 1'b1;
    end else begin
      if (settle_cnt != 2'd0)
        settle_cnt <= settle_cnt - 2'd1;
      if (settle_cnt == 2'd0 && !both_low)
        armed <= 1'b1;
      prev_both_low <= both_low;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO control
  //
  // Fullness is judged on the registered level, so a pop in the same cycle
  // does not open a slot for an event arriving at full. clear wins over both
  // push and pop.
  // ---------------------------------------------------------------------------
  logic [RW-1:0] record;
  logic          is_full;
  logic          capture;
  logic          push;
  logic          drop;
  logic          pop;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign record  = {mod_sync, bus_address, bus_data};
  assign is_full = (level == FULL_LEVEL);
  assign capture = bus_event & record_enable & ~clear;
  assign push    = capture & ~is_full;
  assign drop    = capture &  is_full;
  assign pop     = out_valid & out_ready & ~clear;

  assign out_valid = (level != '0);
  assign out_empty = (level <= LW'(1));

  always_ff @(posedge comm_clock or posedge comm_reset) begin
    if (comm_reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
      dropped  <= '0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
      dropped  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);

      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase

      if (drop) begin
        overflow <= 1'b1;
        if (dropped != 16'hFFFF)
          dropped <= dropped + 16'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Storage: write-synchronous, read-asynchronous, not reset, so it maps to
  // distributed/block RAM with async read or plain registers with identical
  // ordering and latency.
  // ---------------------------------------------------------------------------
  logic [RW-1:0] mem [DEPTH];

  always_ff @(posedge comm_clock) begin
    if (push)
      mem[wr_ptr] <= record;
  end

  assign out_data = mem[rd_ptr];

endmodule

// File: tb/tb_computie_bus_recorder.sv
module tb_computie_bus_recorder;

  localparam int BW = 32;
  localparam int MW = 1;
  localparam int DP = 8;
  localparam int RW = 2*BW + MW;
  localparam int LW = $clog2(DP) + 1;

  localparam int OP_BUS = 0;   // bus cycle, record_enable=1; checks after
  localparam int OP_POP = 1;   // head/empty checked before pop, rest after
  localparam int OP_OFF = 2;   // bus cycle with record_enable=0

  logic            comm_clock;
  logic            comm_reset;
  logic            bus_as_n;
  logic            bus_dtack_n;
  logic [MW-1:0]   bus_mod;
  logic [BW-1:0]   bus_address;
  logic [BW-1:0]   bus_data;
  logic            record_enable;
  logic            clear;
  logic            out_valid;
  logic            out_ready;
  logic [RW-1:0]   out_data;
  logic            out_empty;
  logic [LW-1:0]   level;
  logic            overflow;
  logic [15:0]     dropped;

  int n_cmp  = 0;
  int n_fail = 0;

  computie_bus_recorder #(
    .BITWIDTH(BW),
    .MODWIDTH(MW),
    .DEPTH   (DP)
  ) dut (
    .comm_clock   (comm_clock),
    .comm_reset   (comm_reset),
    .bus_as_n     (bus_as_n),
    .bus_dtack_n  (bus_dtack_n),
    .bus_mod      (bus_mod),
    .bus_address  (bus_address),
    .bus_data     (bus_data),
    .record_enable(record_enable),
    .clear        (clear),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_empty    (out_empty),
    .level        (level),
    .overflow     (overflow),
    .dropped      (dropped)
  );

  initial comm_clock = 1'b0;
  always #5 comm_clock = ~comm_clock;

  typedef struct {
    int          op;
    logic        mod;
    logic [31:0] addr;
    logic [31:0] data;
    int          hold;
    logic [3:0]  exp_level;
    logic        exp_valid;
    logic        exp_empty;
    logic        chk_head;
    logic [64:0] exp_head;
    logic        exp_ovf;
    logic [15:0] exp_drop;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge.
  task automatic bus_cycle(input logic m, input logic [31:0] a, input logic [31:0] d, input int hold);
    bus_mod     = m;
    bus_address = a;
    bus_data    = d;
    bus_as_n    = 1'b0;
    bus_dtack_n = 1'b0;
    repeat (hold) @(negedge comm_clock);
    bus_as_n    = 1'b1;
    bus_dtack_n = 1'b1;
    repeat (4) @(negedge comm_clock);
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    @(negedge comm_clock);
    out_ready = 1'b0;
  endtask

  // Strobes go low now; the event lands on the third rising edge. The
  // caller's action is applied for exactly that cycle.
  task automatic strobe_on(input logic m, input logic [31:0] a, input logic [31:0] d);
    bus_mod     = m;
    bus_address = a;
    bus_data    = d;
    bus_as_n    = 1'b0;
    bus_dtack_n = 1'b0;
    repeat (2) @(negedge comm_clock);
  endtask

  task automatic strobe_off();
    bus_as_n    = 1'b1;
    bus_dtack_n = 1'b1;
    repeat (4) @(negedge comm_clock);
  endtask

  initial begin
    logic [64:0] rec;
    logic        m;

    vecs[0]  = '{OP_BUS, 1'b0, 32'h00100004, 32'hDEADBEEF, 10, 4'd1, 1'b1, 1'b1, 1'b1, 65'h0_00100004_DEADBEEF, 1'b0, 16'd0};
    vecs[1]  = '{OP_POP, 1'b0, 32'h0,        32'h0,         0, 4'd0, 1'b0, 1'b1, 1'b1, 65'h0_00100004_DEADBEEF, 1'b0, 16'd0};
    vecs[2]  = '{OP_BUS, 1'b1, 32'hA0000010, 32'h11111111,  4, 4'd1, 1'b1, 1'b1, 1'b1, 65'h1_A0000010_11111111, 1'b0, 16'd0};
    vecs[3]  = '{OP_BUS, 1'b1, 32'hA0000014, 32'h22222222,  6, 4'd2, 1'b1, 1'b0, 1'b1, 65'h1_A0000010_11111111, 1'b0, 16'd0};
    vecs[4]  = '{OP_BUS, 1'b0, 32'hA0000018, 32'h33333333,  3, 4'd3, 1'b1, 1'b0, 1'b1, 65'h1_A0000010_11111111, 1'b0, 16'd0};
    vecs[5]  = '{OP_POP, 1'b0, 32'h0,        32'h0,         0, 4'd2, 1'b1, 1'b0, 1'b1, 65'h1_A0000010_11111111, 1'b0, 16'd0};
    vecs[6]  = '{OP_POP, 1'b0, 32'h0,        32'h0,         0, 4'd1, 1'b1, 1'b0, 1'b1, 65'h1_A0000014_22222222, 1'b0, 16'd0};
    vecs[7]  = '{OP_POP, 1'b0, 32'h0,        32'h0,         0, 4'd0, 1'b0, 1'b1, 1'b1, 65'h0_A0000018_33333333, 1'b0, 16'd0};
    vecs[8]  = '{OP_OFF, 1'b0, 32'h50000000, 32'h00000001,  4, 4'd0, 1'b0, 1'b1, 1'b0, 65'h0, 1'b0, 16'd0};
    vecs[9]  = '{OP_OFF, 1'b1, 32'h50000004, 32'h00000002,  4, 4'd0, 1'b0, 1'b1, 1'b0, 65'h0, 1'b0, 16'd0};
    vecs[10] = '{OP_OFF, 1'b0, 32'h50000008, 32'h00000003,  5, 4'd0, 1'b0, 1'b1, 1'b0, 65'h0, 1'b0, 16'd0};
    vecs[11] = '{OP_OFF, 1'b1, 32'h5000000C, 32'h00000004,  4, 4'd0, 1'b0, 1'b1, 1'b0, 65'h0, 1'b0, 16'd0};
    vecs[12] = '{OP_OFF, 1'b0, 32'h50000010, 32'h00000005,  8, 4'd0, 1'b0, 1'b1, 1'b0, 65'h0, 1'b0, 16'd0};

    comm_reset    = 1'b1;
    bus_as_n      = 1'b1;
    bus_dtack_n   = 1'b1;
    bus_mod       = '0;
    bus_address   = '0;
    bus_data      = '0;
    record_enable = 1'b1;
    clear         = 1'b0;
    out_ready     = 1'b0;

    repeat (3) @(negedge comm_clock);
    check("reset level",    level,     0);
    check("reset valid",    out_valid, 0);
    check("reset empty",    out_empty, 1);
    check("reset overflow", overflow,  0);
    check("reset dropped",  dropped,   0);
    comm_reset = 1'b0;
    repeat (4) @(negedge comm_clock);

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].op == OP_POP) begin
        if (vecs[i].chk_head)
          check($sformatf("vec%0d head", i), out_data, vecs[i].exp_head);
        check($sformatf("vec%0d empty", i), out_empty, vecs[i].exp_empty);
        pop_one();
      end else begin
        record_enable = (vecs[i].op == OP_BUS);
        bus_cycle(vecs[i].mod, vecs[i].addr, vecs[i].data, vecs[i].hold);
        record_enable = 1'b1;
        if (vecs[i].chk_head)
          check($sformatf("vec%0d head", i), out_data, vecs[i].exp_head);
        check($sformatf("vec%0d empty", i), out_empty, vecs[i].exp_empty);
      end
      check($sformatf("vec%0d level", i),    level,     vecs[i].exp_level);
      check($sformatf("vec%0d valid", i),    out_valid, vecs[i].exp_valid);
      check($sformatf("vec%0d overflow", i), overflow,  vecs[i].exp_ovf);
      check($sformatf("vec%0d dropped", i),  dropped,   vecs[i].exp_drop);
    end

    // ---------------- overflow and pointer wrap ----------------
    for (int i = 0; i < DP + 3; i++) begin
      m = i[0];
      bus_cycle(m, 32'hB0000000 + i, 32'hC0000000 + i, 4);
    end
    check("ovf level",    level,     DP);
    check("ovf overflow", overflow,  1);
    check("ovf dropped",  dropped,   3);
    check("ovf empty",    out_empty, 0);
    for (int i = 0; i < DP; i++) begin
      m   = i[0];
      rec = {m, 32'hB0000000 + i, 32'hC0000000 + i};
      check($sformatf("wrap head%0d", i),  out_data,  rec);
      check($sformatf("wrap empty%0d", i), out_empty, (i == DP - 1));
      pop_one();
    end
    check("wrap level", level,     0);
    check("wrap valid", out_valid, 0);

    // ---------------- push with same-cycle pop at level 1 ----------------
    bus_cycle(1'b0, 32'h00000100, 32'h0000AAAA, 4);
    check("pp1 level", level, 1);
    strobe_on(1'b1, 32'h00000200, 32'h0000BBBB);
    pop_one();
    check("pp1 level same", level,    1);
    check("pp1 head",       out_data, 65'h1_00000200_0000BBBB);
    strobe_off();
    check("pp1 single event", level, 1);
    pop_one();
    check("pp1 drained", level, 0);

    // ---------------- push at full with same-cycle pop ----------------
    for (int i = 0; i < DP; i++)
      bus_cycle(1'b0, 32'hD0000000 + i, 32'h0000D000 + i, 4);
    check("ppf full", level, DP);
    strobe_on(1'b0, 32'hE0000000, 32'h0000EEEE);
    pop_one();
    check("ppf level",    level,    DP - 1);
    check("ppf dropped",  dropped,  4);
    check("ppf overflow", overflow, 1);
    check("ppf head",     out_data, 65'h0_D0000001_0000D001);
    strobe_off();

    // ---------------- clear at level 7, overflow 1 ----------------
    clear = 1'b1;
    @(negedge comm_clock);
    clear = 1'b0;
    check("clr level",    level,     0);
    check("clr overflow", overflow,  0);
    check("clr dropped",  dropped,   0);
    check("clr valid",    out_valid, 0);
    check("clr empty",    out_empty, 1);

    // an event on the clear cycle is lost
    strobe_on(1'b0, 32'h77770000, 32'h00007777);
    clear = 1'b1;
    @(negedge comm_clock);
    clear = 1'b0;
    strobe_off();
    check("clr event lost", level, 0);

    // ---------------- reset mid-strobe ----------------
    for (int i = 0; i < 3; i++)
      bus_cycle(1'b1, 32'hF0000000 + i, 32'h0000F000 + i, 4);
    strobe_on(1'b0, 32'hF0000003, 32'h0000F003);
    repeat (3) @(negedge comm_clock);
    check("rst pre level", level, 4);
    comm_reset = 1'b1;
    #1;
    check("rst async level", level,     0);
    check("rst async valid", out_valid, 0);
    check("rst async empty", out_empty, 1);
    repeat (2) @(negedge comm_clock);
    comm_reset = 1'b0;
    repeat (10) @(negedge comm_clock);
    check("rst held strobe", level, 0);
    strobe_off();
    check("rst released strobe", level, 0);
    bus_cycle(1'b1, 32'h12345678, 32'h9ABCDEF0, 4);
    check("rst new level", level,    1);
    check("rst new head",  out_data, 65'h1_12345678_9ABCDEF0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
